// File: rtl/hilo_muldiv_unit_if.sv
// Bus between the execute-stage controller and the HI/LO multiply/divide unit.
//
// Handshake: start is accepted only on an edge where busy is low; the unit then
// raises busy at that edge and holds it until the commit edge, after which done
// (and div_by_zero for a zero divisor) is high for exactly one cycle with the new
// HI/LO on hi/lo. Requests presented while busy is high are dropped, not queued.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, opA, opB, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, opA, opB, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo, dbg_state
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative mult/multu/div/divu unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, iterated for ITER cycles on
// a shared double-width accumulator, then sign-corrected and committed in FIX.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               clock,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_is_div;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_orig_a;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;
    logic                 w_busy;

    // Operand magnitudes: only the signed ops (op[0] == 0) look at the sign bit.
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    assign w_neg_a = !bus.op[0] && bus.opA[WIDTH-1];
    assign w_neg_b = !bus.op[0] && bus.opB[WIDTH-1];
    assign w_abs_a = w_neg_a ? -bus.opA : bus.opA;
    assign w_abs_b = w_neg_b ? -bus.opB : bus.opB;

    // Shift-add step: multiplier sits in the low half and shifts out as the
    // partial product grows into the high half.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring-division step: high half is the remainder, low half shifts the
    // dividend out while quotient bits shift in. The shifted remainder needs one
    // extra bit; after a successful subtract the result always fits in WIDTH.
    logic [WIDTH:0]       w_div_sh;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_b};
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_b;
    assign w_div_next = {(w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    // Sign fixup applied in FIX. Unsigned ops carry cleared sign flags.
    logic                 w_b_zero;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    assign w_b_zero = (r_b == '0);
    assign w_last   = (r_cnt == CW'(ITER - 1));
    assign w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo    = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and busy decode.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = bus.op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_DIV: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath, HI/LO commit and mthi/mtlo writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_orig_a <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            r_dbz  <= (r_state == S_FIX) && r_is_div && w_b_zero;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_div <= bus.op[1];
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_orig_a <= bus.opA;
                        r_cnt    <= '0;
                        r_acc    <= bus.op[1] ? {{WIDTH{1'b0}}, w_abs_a}
                                              : {{WIDTH{1'b0}}, w_abs_b};
                    end else begin
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (w_b_zero) begin
                        r_hi <= r_orig_a;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed plus randomized bench for hilo_muldiv_unit against an arithmetic model.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    // Model of the architectural HI/LO contents.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W), .ITER(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        longint       sp;
        logic [63:0]  up;
        logic [W-1:0] q;
        logic [W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                sp = sa * sb;
                return {1'b0, 64'(sp)};
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                return {1'b0, up};
            end
            default: begin
                if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = W'(sa / sb);
                    r = W'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    task automatic write_hilo(input logic whi, input logic wlo, input logic [W-1:0] d);
        @(negedge clock);
        bus.mthi  = whi;
        bus.mtlo  = wlo;
        bus.wdata = d;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (whi) m_hi = d;
        if (wlo) m_lo = d;
        check("mt_hi", {32'b0, bus.hi}, {32'b0, m_hi});
        check("mt_lo", {32'b0, bus.lo}, {32'b0, m_lo});
    endtask

    // One operation. inj: cycle at which a start+mthi is injected while busy
    // (0 = none). rst_at: cycle at which reset is pulsed (0 = none).
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, input int rst_at, input logic with_mtlo);
        logic [64:0]  exp_r;
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        logic         ok;
        int           seen;
        exp_r  = ref_op(op, a, b);
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        bus.mtlo  = with_mtlo;
        bus.wdata = 32'h1111_2222;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        check("accept_busy", {63'b0, bus.busy}, 64'd1);
        check("accept_lo_held", {32'b0, bus.lo}, {32'b0, old_lo});
        ok   = 1'b1;
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == inj) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.opA   = $urandom;
                bus.opB   = $urandom;
                bus.mthi  = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (c == rst_at) reset = 1'b1;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
            if (c == rst_at) begin
                reset = 1'b0;
                m_hi  = '0;
                m_lo  = '0;
                check("abort_busy", {63'b0, bus.busy}, 64'd0);
                check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
                for (int k = 0; k < 40; k++) begin
                    @(posedge clock);
                    #1;
                    if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
                end
                check("abort_no_done", {63'b0, ok}, 64'd1);
                return;
            end
            if (bus.done === 1'b1) begin
                seen = c;
                break;
            end
            if (bus.busy !== 1'b1 || bus.div_by_zero !== 1'b0 ||
                bus.hi !== old_hi || bus.lo !== old_lo) ok = 1'b0;
        end
        m_hi = exp_r[63:32];
        m_lo = exp_r[31:0];
        check("inflight_stable", {63'b0, ok}, 64'd1);
        check("latency", 64'(seen), 64'd33);
        check("result_busy_low", {63'b0, bus.busy}, 64'd0);
        check("result_hi", {32'b0, bus.hi}, {32'b0, m_hi});
        check("result_lo", {32'b0, bus.lo}, {32'b0, m_lo});
        check("result_dbz", {63'b0, bus.div_by_zero}, {63'b0, exp_r[64]});
        @(posedge clock);
        #1;
        check("done_pulse_end", {62'b0, bus.done, bus.div_by_zero}, 64'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        m_hi      = '0;
        m_lo      = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opA   = '0;
        bus.opB   = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_flags", {61'b0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        reset = 1'b0;

        // Directed steps.
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 1'b0);
        check("mult_neg3x7", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        check("multu_max", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 1'b0);
        check("div_neg7by2", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, 0, 0, 1'b0);
        run_op(2'b11, 32'h0000_1234, 32'h0, 0, 0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        check("div_overflow", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_0F00, 5, 0, 1'b0);
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_0F00, 0, 10, 1'b0);
        write_hilo(1'b0, 1'b1, 32'hCAFE_F00D);
        write_hilo(1'b1, 1'b1, 32'h1357_9BDF);
        run_op(2'b01, 32'h0000_0003, 32'h0000_0005, 0, 0, 1'b1);

        // Randomized operations interleaved with HI/LO writes.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(rop, ra, rb, (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0),
                   0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Sequential multiply/divide unit that owns the architectural HI and LO registers of the MIPS datapath.
- The execute stage issues mult, multu, div and divu operands; this block iterates for 32 cycles and commits the results to HI/LO.
- It also services mthi/mtlo writes and drives HI/LO to the mfhi/mflo writeback path.
- A busy/done handshake lets the controller stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a mult/div operation; sampled only in IDLE.
- op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu (equal to funct[1:0]).
- opA  input  WIDTH  rs value; multiplicand or dividend.
- opB  input  WIDTH  rt value; multiplier or divisor.
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_by_zero  output  1  pulses with done when a div/divu had opB == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state = IDLE; hi = lo = 0; busy = done = div_by_zero = 0.
  - Applies mid-operation: the operation is aborted and no partial result reaches HI/LO.
- States: IDLE -> MUL or DIV -> FIX -> IDLE.
- IDLE:
  - start = 1: latch op. For signed ops, latch |opA|, |opB| and the sign flags; for unsigned ops, latch the raw values. Clear iteration counter. Go to MUL (op[1] = 0) or DIV (op[1] = 1).
  - busy rises at this accepting edge (E0).
  - Otherwise mthi/mtlo write wdata into hi/lo at the next edge. Both asserted together write both registers.
  - start together with mthi/mtlo: start wins and the writes are dropped.
- MUL: 32 shift-add iterations, one per cycle, on a 64-bit product accumulator.
- DIV: 32 restoring-division iterations, one per cycle, producing a 32-bit remainder and quotient.
- Counter reaching ITER-1 moves the FSM to FIX.
- FIX (one cycle):
  - Apply sign correction. Product is negated if the sign flags differ. Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Commit at edge E33: mult -> {hi, lo} = 64-bit product; div -> lo = quotient, hi = remainder.
  - busy falls at E33; done = 1 for the cycle after E33; return to IDLE.
- Latency: result is visible in hi/lo 33 cycles after the accepting edge.
- Divide by zero (opB == 0, signed or unsigned):
  - Sign fixup is bypassed: hi = original opA, lo = 32'hFFFFFFFF.
  - div_by_zero = 1 with done.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0; no flag.
- While busy:
  - start, mthi and mtlo are ignored (no queueing).
  - hi/lo keep their previous values until the commit; the controller stalls mfhi/mflo on busy.
- done and div_by_zero are low in every cycle other than the single result cycle.

Test Plan:
- mult opA = FFFFFFFD (-3), opB = 00000007 -> busy for 33 cycles, then done pulse; hi = FFFFFFFF, lo = FFFFFFEB.
- multu opA = opB = FFFFFFFF -> hi = FFFFFFFE, lo = 00000001. Then mult with the same operands -> hi = 00000000, lo = 00000001.
- div opA = FFFFFFF9 (-7), opB = 2 -> lo = FFFFFFFD, hi = FFFFFFFF. divu opA = 100, opB = 7 -> lo = 0000000E, hi = 00000002.
- divu opA = 00001234, opB = 0 -> hi = 00001234, lo = FFFFFFFF, div_by_zero = 1 for one cycle with done. div 80000000 / FFFFFFFF -> lo = 80000000, hi = 0, div_by_zero = 0.
- Start a mult; at cycle 5 pulse start with different operands and pulse mthi = DEADBEEF -> both ignored, original result committed. Repeat with reset at cycle 10 -> busy = 0, hi = lo = 0, no done pulse.
- In IDLE, mtlo with wdata = CAFEF00D -> lo = CAFEF00D next cycle. mthi and mtlo together -> both equal wdata. start with mtlo in the same cycle -> mtlo dropped, operation runs.
